// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the two-stage instruction memory.
// Optional retired-instruction counter enabled by defining FETCH_SEQ_COUNT_EN.
module fetch_sequencer #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          MEM_LAT  = 2,
    parameter logic [4:0]           HALT_OPC = 5'b11111,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [4:0]        opcode,
    output logic [ADDR_W-1:0] Address,
    output logic              instRead,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
`ifdef FETCH_SEQ_COUNT_EN
    output logic [15:0]       retired_count,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [ADDR_W-1:0]  pc_out_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               accept;

`ifdef FETCH_SEQ_COUNT_EN
    logic [15:0]        retired_n;
`endif

    // Next state, next PC and wait-counter update
    always_comb begin
        state_n  = state;
        pc_n     = Address;
        cnt_n    = cnt;
        pc_out_n = pc_out;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_n    = RESET_PC;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = CNT_W'(MEM_LAT - 1);
                state_n = (MEM_LAT == 1) ? VALID : WAIT;
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_n = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    accept = 1'b1;
                    if (opcode == HALT_OPC) begin
                        state_n = HALT;
                    end else if (branch_take) begin
                        pc_n    = branch_target;
                        state_n = ISSUE;
                    end else begin
                        pc_n    = Address + ADDR_W'(1);
                        state_n = ISSUE;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    pc_n    = RESET_PC;
                    state_n = ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == VALID) begin
            pc_out_n = pc_n;
        end
    end

`ifdef FETCH_SEQ_COUNT_EN
    // Saturating retire counter; cleared on restart out of HALT
    always_comb begin
        retired_n = retired_count;
        if (accept && (retired_count != 16'hFFFF)) begin
            retired_n = retired_count + 16'd1;
        end else if ((state == HALT) && start) begin
            retired_n = '0;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            retired_count <= '0;
        end else begin
            retired_count <= retired_n;
        end
    end
`endif

    // State register with all outputs derived from the next state
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            Address    <= RESET_PC;
            pc_out     <= RESET_PC;
            cnt        <= '0;
            instRead   <= 1'b0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            Address    <= pc_n;
            pc_out     <= pc_out_n;
            cnt        <= cnt_n;
            instRead   <= (state_n == ISSUE);
            inst_valid <= (state_n == VALID);
            halted     <= (state_n == HALT);
            busy       <= (state_n == ISSUE) || (state_n == WAIT) || (state_n == VALID);
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that sequences the 25-bit instruction memory (8-bit address, registered two-stage output).
- Drives Address/instRead, waits out the memory latency, and presents a one-instruction-at-a-time valid handshake to decode.
- Applies branch redirects and stops on a HALT opcode.
- Sits between the instruction memory and the decode/execute control.

Parameters:
- ADDR_W, 8, instruction address width.
- MEM_LAT, 2, cycles from the instRead cycle until the memory's opcode/field outputs are valid; legal range 1..7.
- HALT_OPC, 5'b11111, opcode that stops fetching.
- RESET_PC, 8'h00, start address after reset and on restart.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin fetching from RESET_PC; sampled only in IDLE and HALT.
- stall  in  1  decode not ready; holds the current valid instruction.
- branch_take  in  1  redirect request; sampled only on instruction accept.
- branch_target  in  ADDR_W  redirect address.
- opcode  in  5  opcode field returned by the instruction memory.
- Address  out  ADDR_W  fetch address to memory; equals the PC register.
- instRead  out  1  memory read strobe; one cycle per fetch.
- inst_valid  out  1  memory fields hold the instruction at pc_out.
- pc_out  out  ADDR_W  address of the instruction currently flagged valid.
- halted  out  1  HALT opcode accepted; fetching stopped.
- busy  out  1  high in ISSUE, WAIT and VALID.

Behaviour:
- All outputs are registered.
- Reset values:
  - Address = pc_out = RESET_PC
  - instRead = inst_valid = halted = busy = 0
  - wait counter = 0
  - state = IDLE
- Reset asserted mid-operation: return to IDLE immediately and discard the in-flight fetch. No inst_valid is produced for it.
- States: IDLE, ISSUE, WAIT, VALID, HALT.
- IDLE: start=1 -> pc=RESET_PC, go to ISSUE.
- ISSUE:
  - instRead=1 for exactly this cycle; Address = pc.
  - Load the wait counter with MEM_LAT-1.
  - Go to WAIT, or directly to VALID if MEM_LAT=1.
- WAIT:
  - instRead=0; decrement the counter.
  - Counter reaches 0 -> go to VALID.
  - If the instRead cycle is C, inst_valid first rises in cycle C+MEM_LAT.
- VALID:
  - inst_valid=1; pc_out = pc.
  - stall=1: hold state, inst_valid, pc and Address. branch_take is ignored.
  - stall=0 (accept):
    - opcode==HALT_OPC -> HALT. Takes priority over branch_take.
    - else branch_take=1 -> pc=branch_target, go to ISSUE.
    - else pc=pc+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00), go to ISSUE.
  - inst_valid drops in the cycle after accept.
- Throughput: one instruction per MEM_LAT+1 cycles with no stall.
- HALT:
  - halted=1, busy=0, inst_valid=0, instRead=0.
  - start=1 -> clear halted, pc=RESET_PC, go to ISSUE.
- stall is ignored in IDLE, ISSUE, WAIT and HALT. A fetch in flight always completes.
- start is ignored while busy=1.
- stall=1 and branch_take=1 together in VALID: stall wins and the branch is not taken.

Optional Feature:
- Macro: FETCH_SEQ_COUNT_EN.
- Defined: adds output retired_count (16 bits), reset 0.
  - Increments by 1 on every VALID accept, including the HALT instruction.
  - Saturates at 16'hFFFF.
  - Cleared when start is accepted from HALT.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset release, start pulse in cycle 0 -> ISSUE in cycle 1 with Address=8'h00, instRead=1. inst_valid=1 in cycle 3 (MEM_LAT=2) with pc_out=8'h00. Next instRead in cycle 4 with Address=8'h01.
- stall held high for 3 cycles during VALID at pc=8'h05 -> inst_valid stays 1 and pc_out stays 8'h05 for 4 cycles. branch_take=1 during the stall is ignored. Next fetch is 8'h06.
- Accept with branch_take=1, branch_target=8'h40 at pc=8'h10 -> next instRead has Address=8'h40. Separately, pc=8'hFF with no branch -> next Address=8'h00.
- opcode=5'b11111 accepted with branch_take=1 -> halted=1, no further instRead. start=1 -> halted=0 and the fetch restarts at 8'h00.
- Reset driven low in WAIT -> outputs return to reset values within the same cycle. No inst_valid follows; the FSM stays in IDLE until start.
- FETCH_SEQ_COUNT_EN defined, 5 accepts then HALT -> retired_count=6. Preloaded count at 16'hFFFF -> stays 16'hFFFF after a further accept.
